seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_if.sv | 24 ++
 rtl/seg7_scan_driver.sv | 140 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Bundle of load-side inputs and scan-side outputs for the multiplexed 7-segment driver.
interface seg7_scan_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      load;
   logic [4*NUM_DIGITS-1:0]   value;
   logic [NUM_DIGITS-1:0]     dp;
   logic [NUM_DIGITS-1:0]     blank;
   logic                      lz_en;
   logic [7:0]                seg7;
   logic [NUM_DIGITS-1:0]     seg_en;
   logic                      pending;
   logic                      frame_done;

   modport master (
      output load, value, dp, blank, lz_en,
      input  seg7, seg_en, pending, frame_done
   );

   modport slave (
      input  load, value, dp, blank, lz_en,
      output seg7, seg_en, pending, frame_done
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-boundary commit of
// double-buffered display data, leading-zero suppression and dead-time ghost suppression.
module seg7_scan_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int CLK_DIV        = 50000,
   parameter int DEAD_CYCLES    = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit EN_ACTIVE_LOW  = 1'b0
) (
   input logic        clk,
   input logic        rst_n,
   seg7_scan_if.slave bus
);

   localparam int PTR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = $clog2(CLK_DIV);
   localparam logic [7:0]            DARK   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] EN_OFF = {NUM_DIGITS{EN_ACTIVE_LOW}};

   // Hex nibble to active-low pgfedcba, then to the board's segment polarity.
   function automatic logic [7:0] digit_pattern(input logic [3:0] nib,
                                                input logic       dp_on,
                                                input logic       dark);
      logic [7:0] raw;
      case (nib)
         4'h0: raw = 8'hC0;  4'h1: raw = 8'hF9;  4'h2: raw = 8'hA4;  4'h3: raw = 8'hB0;
         4'h4: raw = 8'h99;  4'h5: raw = 8'h92;  4'h6: raw = 8'h82;  4'h7: raw = 8'hF8;
         4'h8: raw = 8'h80;  4'h9: raw = 8'h90;  4'hA: raw = 8'h88;  4'hB: raw = 8'h83;
         4'hC: raw = 8'hC6;  4'hD: raw = 8'hA1;  4'hE: raw = 8'h86;  default: raw = 8'h8E;
      endcase
      if (dp_on) raw[7] = 1'b0;
      if (dark)  raw = 8'hFF;
      return SEG_ACTIVE_LOW ? raw : ~raw;
   endfunction

   logic [CNT_W-1:0]          cnt;
   logic [PTR_W-1:0]          ptr;
   logic [4*NUM_DIGITS-1:0]   pend_value, disp_value;
   logic [NUM_DIGITS-1:0]     pend_dp, pend_blank, disp_dp, disp_blank;
   logic                      pend_lz, disp_lz, pending;
   logic [7:0]                seg_p1;
   logic [NUM_DIGITS-1:0]     en_p1;
   logic                      frame_done_p1;

   logic                            slot_wrap, frame_wrap, dead;
   logic [3:0]                      nib;
   logic                            higher_dark;
   logic [NUM_DIGITS-1:0]           sup;
   logic [NUM_DIGITS-1:0][7:0]      pat;
   logic [7:0]                      seg_nxt;
   logic [NUM_DIGITS-1:0]           en_nxt;

   assign slot_wrap  = (cnt == CNT_W'(CLK_DIV - 1));
   assign frame_wrap = slot_wrap && (ptr == PTR_W'(NUM_DIGITS - 1));
   assign dead       = int'(cnt) < DEAD_CYCLES;

   // Scan from the top digit down so "every higher digit is zero or blank" is a running flag.
   always_comb begin
      nib         = 4'h0;
      higher_dark = 1'b1;
      sup         = '0;
      pat         = '0;
      for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
         nib         = disp_value[4*d +: 4];
         sup[d]      = disp_lz && (d != 0) && (nib == 4'h0) && higher_dark;
         higher_dark = higher_dark && ((nib == 4'h0) || disp_blank[d]);
         pat[d]      = digit_pattern(nib, disp_dp[d], disp_blank[d] || sup[d]);
      end
   end

   always_comb begin
      seg_nxt = DARK;
      en_nxt  = EN_OFF;
      if (!dead) begin
         seg_nxt = pat[ptr];
         en_nxt  = (NUM_DIGITS'(1) << ptr) ^ EN_OFF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= '0;
         ptr           <= '0;
         pend_value    <= '0;
         pend_dp       <= '0;
         pend_blank    <= '0;
         pend_lz       <= 1'b0;
         pending       <= 1'b0;
         disp_value    <= '0;
         disp_dp       <= '0;
         disp_blank    <= '0;
         disp_lz       <= 1'b0;
         seg_p1        <= DARK;
         en_p1         <= EN_OFF;
         frame_done_p1 <= 1'b0;
      end else begin
         if (slot_wrap) begin
            cnt <= '0;
            ptr <= frame_wrap ? '0 : ptr + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end

         // Output stage: pattern for the (cnt, ptr) sampled at this edge
         seg_p1        <= seg_nxt;
         en_p1         <= en_nxt;
         frame_done_p1 <= frame_wrap;

         // A load landing on the frame wrap bypasses the pending buffer entirely.
         if (frame_wrap && bus.load) begin
            disp_value <= bus.value;
            disp_dp    <= bus.dp;
            disp_blank <= bus.blank;
            disp_lz    <= bus.lz_en;
            pending    <= 1'b0;
         end else begin
            if (frame_wrap && pending) begin
               disp_value <= pend_value;
               disp_dp    <= pend_dp;
               disp_blank <= pend_blank;
               disp_lz    <= pend_lz;
               pending    <= 1'b0;
            end
            if (bus.load) begin
               pend_value <= bus.value;
               pend_dp    <= bus.dp;
               pend_blank <= bus.blank;
               pend_lz    <= bus.lz_en;
               pending    <= 1'b1;
            end
         end
      end
   end

   assign bus.seg7       = seg_p1;
   assign bus.seg_en     = en_p1;
   assign bus.pending    = pending;
   assign bus.frame_done = frame_done_p1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a frame-level reference model predicts every
// output cycle for a default-polarity DUT and an inverted-polarity twin sharing the same inputs.
module tb_seg7_scan_driver;

   localparam int ND   = 4;
   localparam int CD   = 8;
   localparam int DEAD = 2;
   localparam int F    = ND * CD;

   localparam logic [7:0] SEG_TBL [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   typedef struct packed {
      logic [15:0] v;
      logic [3:0]  dp;
      logic [3:0]  blk;
      logic        lz;
   } frame_t;

   typedef struct packed {
      logic [7:0] seg;
      logic [3:0] en;
      logic       pend;
      logic       fd;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seg7_scan_if #(.NUM_DIGITS(ND)) bif ();
   seg7_scan_if #(.NUM_DIGITS(ND)) bif2 ();

   assign bif2.load  = bif.load;
   assign bif2.value = bif.value;
   assign bif2.dp    = bif.dp;
   assign bif2.blank = bif.blank;
   assign bif2.lz_en = bif.lz_en;

   seg7_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .DEAD_CYCLES(DEAD),
                      .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b0))
      dut (.clk(clk), .rst_n(rst_n), .bus(bif));

   seg7_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .DEAD_CYCLES(DEAD),
                      .SEG_ACTIVE_LOW(1'b0), .EN_ACTIVE_LOW(1'b1))
      dut_inv (.clk(clk), .rst_n(rst_n), .bus(bif2));

   int      n_vec = 0;
   int      n_err = 0;
   exp_t    sb[$];
   frame_t  disp, pend;
   bit      pflag;
   int      k;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at t=%0t (edge %0d)", nm, act, exp, $time, k);
      end
   endtask

   // Reference: what the display shows for digit d of a committed frame.
   function automatic logic [7:0] ref_digit(input int d, input frame_t f);
      logic [3:0] nib;
      logic       dark, hi_zero;
      nib  = 4'((f.v >> (4 * d)) & 16'hF);
      dark = f.blk[d];
      if (f.lz && d > 0 && nib == 4'h0) begin
         hi_zero = 1'b1;
         for (int j = d + 1; j < ND; j++)
            if (((f.v >> (4 * j)) & 16'hF) != 16'h0 && !f.blk[j]) hi_zero = 1'b0;
         if (hi_zero) dark = 1'b1;
      end
      if (dark) return 8'hFF;
      return SEG_TBL[nib] & (f.dp[d] ? 8'h7F : 8'hFF);
   endfunction

   function automatic logic [15:0] rand_val();
      logic [15:0] v = '0;
      for (int i = 0; i < 4; i++) v[4*i +: 4] = ($urandom % 2 == 1) ? 4'($urandom) : 4'h0;
      return v;
   endfunction

   // Drives one cycle's inputs, predicts the outputs after the coming edge, then waits for negedge.
   task automatic cycle(input bit ld, input logic [15:0] v, input logic [3:0] d,
                        input logic [3:0] b, input bit lz);
      exp_t   e;
      frame_t in;
      int     pos, slot, off;
      bif.load  = ld;
      bif.value = v;
      bif.dp    = d;
      bif.blank = b;
      bif.lz_en = lz;
      in   = '{v: v, dp: d, blk: b, lz: lz};
      k++;
      pos  = (k - 1) % F;
      slot = pos / CD;
      off  = pos % CD;
      if (off < DEAD) begin
         e.seg = 8'hFF;
         e.en  = 4'h0;
      end else begin
         e.seg = ref_digit(slot, disp);
         e.en  = 4'(1 << slot);
      end
      e.fd = (pos == F - 1);
      if (pos == F - 1) begin
         if (ld) begin
            disp  = in;
            pflag = 1'b0;
         end else if (pflag) begin
            disp  = pend;
            pflag = 1'b0;
         end
      end else if (ld) begin
         pend  = in;
         pflag = 1'b1;
      end
      e.pend = pflag;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
   endtask

   task automatic model_reset();
      k     = 0;
      disp  = '0;
      pend  = '0;
      pflag = 1'b0;
   endtask

   // Asynchronous reset mid-cycle; outputs must go dark at once, before any clock edge.
   task automatic do_reset();
      bif.load = 1'b0;
      sb.delete();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_seg7",       bif.seg7,             8'hFF);
      chk("rst_seg_en",     {4'h0, bif.seg_en},   8'h00);
      chk("rst_pending",    {7'h0, bif.pending},  8'h00);
      chk("rst_frame_done", {7'h0, bif.frame_done}, 8'h00);
      chk("rst_inv_seg7",   bif2.seg7,            8'h00);
      chk("rst_inv_seg_en", {4'h0, bif2.seg_en},  8'h0F);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL sb_underflow: output cycle with no expectation at t=%0t", $time);
            end else begin
               e = sb.pop_front();
               chk("seg7",           bif.seg7,                 e.seg);
               chk("seg_en",         {4'h0, bif.seg_en},       {4'h0, e.en});
               chk("pending",        {7'h0, bif.pending},      {7'h0, e.pend});
               chk("frame_done",     {7'h0, bif.frame_done},   {7'h0, e.fd});
               chk("inv_seg7",       bif2.seg7,                ~e.seg);
               chk("inv_seg_en",     {4'h0, bif2.seg_en},      {4'h0, ~e.en});
               chk("inv_pending",    {7'h0, bif2.pending},     {7'h0, e.pend});
               chk("inv_frame_done", {7'h0, bif2.frame_done},  {7'h0, e.fd});
            end
         end
      end
   end

   initial begin : driver
      bit          ld;
      logic [15:0] v;
      bif.load  = 1'b0;
      bif.value = '0;
      bif.dp    = '0;
      bif.blank = '0;
      bif.lz_en = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("reset_seg7",   bif.seg7,           8'hFF);
      chk("reset_seg_en", {4'h0, bif.seg_en}, 8'h00);
      rst_n = 1'b1;

      // Idle scan with a load at edge 5; next frame shows 12AF with dp on digit 2.
      idle(4);
      cycle(1'b1, 16'h12AF, 4'b0100, 4'b0000, 1'b0);
      idle(27);
      idle(32);

      // Two loads in one frame: only the second is committed.
      idle(4);
      cycle(1'b1, 16'h1111, 4'h0, 4'h0, 1'b0);
      idle(10);
      cycle(1'b1, 16'h2222, 4'h0, 4'h0, 1'b0);
      idle(16);
      idle(32);

      // Load exactly on the commit edge with leading-zero suppression.
      idle(31);
      cycle(1'b1, 16'h0003, 4'h0, 4'h0, 1'b1);
      idle(32);

      // Blank on digit 3, dp on digit 0.
      cycle(1'b1, 16'h8888, 4'b0001, 4'b1000, 1'b0);
      idle(31);
      idle(32);

      // Reset at edge 13 of a frame while a load is pending.
      idle(4);
      cycle(1'b1, 16'h5A5A, 4'hF, 4'h0, 1'b0);
      idle(7);
      do_reset();
      idle(40);

      // Randomized traffic, biased toward zero nibbles and loads on the wrap edge.
      for (int i = 0; i < 1600; i++) begin
         if (i == 800) do_reset();
         ld = ($urandom % 10 == 0);
         if ((k + 1) % F == 0 && $urandom % 2 == 1) ld = 1'b1;
         v = rand_val();
         cycle(ld, v, 4'($urandom), ($urandom % 3 == 0) ? 4'($urandom) : 4'h0, 1'($urandom));
      end
      idle(F);

      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
